// File: rtl/mprj2_seq_pkg.sv
// Shared types and defaults for the domain-2 enable sequencer.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
// Contents: sequencer state encoding (OFF = 0), default timing constants,
//           enable/busy output bundle and its per-state decode.
package mprj2_seq_pkg;

   localparam int SYNC_STAGES_DEF   = 2;
   localparam int SETTLE_CYCLES_DEF = 16;
   localparam int STAGE_GAP_DEF     = 4;
   localparam int CNT_W_DEF         = 8;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_UP_IO = 3'd1,
      ST_UP_LA = 3'd2,
      ST_UP_WB = 3'd3,
      ST_ON    = 3'd4,
      ST_DN_WB = 3'd5,
      ST_DN_LA = 3'd6,
      ST_DN_IO = 3'd7
   } seq_state_e;

   typedef struct packed {
      logic io;
      logic la;
      logic wb;
      logic busy;
   } seq_out_t;

   // Enable pattern held in each state. Every pattern keeps wb -> la -> io.
   function automatic seq_out_t state_outputs(input seq_state_e s);
      seq_out_t o;
      o = '0;
      unique case (s)
         ST_OFF:   o = '{io: 1'b0, la: 1'b0, wb: 1'b0, busy: 1'b0};
         ST_UP_IO: o = '{io: 1'b1, la: 1'b0, wb: 1'b0, busy: 1'b1};
         ST_UP_LA: o = '{io: 1'b1, la: 1'b1, wb: 1'b0, busy: 1'b1};
         ST_UP_WB: o = '{io: 1'b1, la: 1'b1, wb: 1'b1, busy: 1'b1};
         ST_ON:    o = '{io: 1'b1, la: 1'b1, wb: 1'b1, busy: 1'b0};
         ST_DN_WB: o = '{io: 1'b1, la: 1'b1, wb: 1'b0, busy: 1'b1};
         ST_DN_LA: o = '{io: 1'b1, la: 1'b0, wb: 1'b0, busy: 1'b1};
         ST_DN_IO: o = '{io: 1'b0, la: 1'b0, wb: 1'b0, busy: 1'b1};
         default:  o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/mprj2_hi_debounce.sv
// Synchronizes the domain-2 tie-high into the management clock and debounces it.
// Latency: pwr_good_o rises SYNC_STAGES + SETTLE_CYCLES edges after hi_async_i
//          rises; it falls combinationally in the cycle the synchronized HI is 0.
// Backpressure: none (level in, level out).
// Ports: clock, resetn (sync, active-low), hi_async_i (async HI), pwr_good_o.
module mprj2_hi_debounce
   import mprj2_seq_pkg::*;
#(
   parameter int SYNC_STAGES   = SYNC_STAGES_DEF,    // >= 2
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,  // >= 1
   parameter int CNT_W         = CNT_W_DEF           // 2^CNT_W > SETTLE_CYCLES
) (
   input  logic clock,
   input  logic resetn,
   input  logic hi_async_i,
   output logic pwr_good_o
);

   localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] SETTLE_M1  = CNT_W'(SETTLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       settle_q, settle_d;
   logic                   settled_q, settled_d;
   logic                   hi_s;

   assign hi_s   = sync_q[SYNC_STAGES-1];
   assign sync_d = {sync_q[SYNC_STAGES-2:0], hi_async_i};

   always_comb begin
      // Counts consecutive cycles of hi_s = 1; parks at SETTLE_CYCLES instead of wrapping.
      settle_d = '0;
      if (hi_s) begin
         settle_d = (settle_q == SETTLE_MAX) ? settle_q : settle_q + 1'b1;
      end
      // The edge that samples the SETTLE_CYCLES-th high cycle raises settled.
      settled_d = hi_s && (settle_q >= SETTLE_M1);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         sync_q    <= '0;
         settle_q  <= '0;
         settled_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         settle_q  <= settle_d;
         settled_q <= settled_d;
      end
   end

   // Gated with hi_s so a loss of HI is reported in the very cycle it is seen.
   assign pwr_good_o = hi_s & settled_q;

endmodule

// File: rtl/mprj2_enable_sequencer.sv
// Stages domain-2 gating enables up (IO, LA, WB) on debounced power + mgmt request, down in reverse.
// Latency: io_ena_o rises SYNC_STAGES + SETTLE_CYCLES + 1 edges after HI rises; STAGE_GAP between stages.
// Backpressure: none; teardown runs to OFF before any new request is honoured.
// Ports: clock, resetn (sync, active-low), hi_async_i, mgmt_ena_i -> io/la/wb_ena_o, pwr_good_o,
//        seq_busy_o; with MPRJ2_SEQ_FAULT_EN defined also fault_o (sticky) and fault_cnt_o (sat. 15).
module mprj2_enable_sequencer
   import mprj2_seq_pkg::*;
#(
   parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int STAGE_GAP     = STAGE_GAP_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       hi_async_i,
   input  logic       mgmt_ena_i,
   output logic       io_ena_o,
   output logic       la_ena_o,
   output logic       wb_ena_o,
   output logic       pwr_good_o,
   output logic       seq_busy_o
`ifdef MPRJ2_SEQ_FAULT_EN
   ,
   output logic       fault_o,
   output logic [3:0] fault_cnt_o
`endif
);

   localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(STAGE_GAP - 1);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   seq_out_t         out_q, out_d;
   logic             pwr_good;
   logic             gap_done;
   seq_state_e       dn_entry;

   mprj2_hi_debounce #(
      .SYNC_STAGES   (SYNC_STAGES),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_hi_debounce (
      .clock      (clock),
      .resetn     (resetn),
      .hi_async_i (hi_async_i),
      .pwr_good_o (pwr_good)
   );

   assign gap_done = (gap_q == GAP_M1);

   // Teardown starts at the highest enable currently on, so it drops first.
   assign dn_entry = out_q.wb ? ST_DN_WB :
                     out_q.la ? ST_DN_LA : ST_DN_IO;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_OFF:
            if (pwr_good && mgmt_ena_i) state_d = ST_UP_IO;
         ST_UP_IO:
            if (!pwr_good || !mgmt_ena_i) state_d = dn_entry;
            else if (gap_done)            state_d = ST_UP_LA;
         ST_UP_LA:
            if (!pwr_good || !mgmt_ena_i) state_d = dn_entry;
            else if (gap_done)            state_d = ST_UP_WB;
         ST_UP_WB:
            if (!pwr_good || !mgmt_ena_i) state_d = dn_entry;
            else if (gap_done)            state_d = ST_ON;
         ST_ON:
            if (!pwr_good || !mgmt_ena_i) state_d = dn_entry;
         // Teardown ignores mgmt_ena_i; only a power loss shortcuts it to OFF.
         ST_DN_WB:
            if (!pwr_good)     state_d = ST_OFF;
            else if (gap_done) state_d = ST_DN_LA;
         ST_DN_LA:
            if (!pwr_good)     state_d = ST_OFF;
            else if (gap_done) state_d = ST_DN_IO;
         ST_DN_IO:
            if (!pwr_good)     state_d = ST_OFF;
            else if (gap_done) state_d = ST_OFF;
         default:
            state_d = ST_OFF;
      endcase

      // Reload on every state change; hold once done so it never wraps in OFF/ON.
      if (state_d != state_q) gap_d = '0;
      else if (gap_done)      gap_d = gap_q;
      else                    gap_d = gap_q + 1'b1;

      // Outputs registered from the next state: they change on the entry edge.
      out_d = state_outputs(state_d);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= ST_OFF;
         gap_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         out_q   <= out_d;
      end
   end

   assign io_ena_o   = out_q.io;
   assign la_ena_o   = out_q.la;
   assign wb_ena_o   = out_q.wb;
   assign seq_busy_o = out_q.busy;
   assign pwr_good_o = pwr_good;

`ifdef MPRJ2_SEQ_FAULT_EN
   logic       fault_q, fault_d;
   logic [3:0] fault_cnt_q, fault_cnt_d;
   logic       mgmt_prev_q;
   logic       fault_evt;
   logic       fault_clr;

   // Power can only be low in UP_*/ON if it fell after that state was entered.
   assign fault_evt = (state_q inside {ST_UP_IO, ST_UP_LA, ST_UP_WB, ST_ON}) && !pwr_good;
   assign fault_clr = (state_q == ST_OFF) && mgmt_prev_q && !mgmt_ena_i;

   always_comb begin
      fault_d     = fault_q;
      fault_cnt_d = fault_cnt_q;
      if (fault_evt) begin
         fault_d = 1'b1;
         if (fault_cnt_q != 4'hF) fault_cnt_d = fault_cnt_q + 1'b1;
      end else if (fault_clr) begin
         fault_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         fault_q     <= 1'b0;
         fault_cnt_q <= '0;
         mgmt_prev_q <= 1'b0;
      end else begin
         fault_q     <= fault_d;
         fault_cnt_q <= fault_cnt_d;
         mgmt_prev_q <= mgmt_ena_i;
      end
   end

   assign fault_o     = fault_q;
   assign fault_cnt_o = fault_cnt_q;
`endif

endmodule

// File: tb/tb_mprj2_enable_sequencer.sv
// Bench for mprj2_enable_sequencer: directed timing pins plus random HI/mgmt/reset traffic,
// every cycle checked against a level/timer model of the enable ladder.
// Fault outputs are exercised when MPRJ2_SEQ_FAULT_EN is defined.
module tb_mprj2_enable_sequencer;

   localparam int SYNC   = 2;
   localparam int SETTLE = 16;
   localparam int GAP    = 4;
   localparam int M_OFF  = 0;
   localparam int M_UP   = 1;
   localparam int M_ON   = 2;
   localparam int M_DN   = 3;

   logic clock = 1'b0;
   logic resetn = 1'b1;
   logic hi_async_i = 1'b0;
   logic mgmt_ena_i = 1'b0;
   logic io_ena_o, la_ena_o, wb_ena_o, pwr_good_o, seq_busy_o;
`ifdef MPRJ2_SEQ_FAULT_EN
   logic       fault_o;
   logic [3:0] fault_cnt_o;
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   always #5 clock = ~clock;

   mprj2_enable_sequencer #(
      .SYNC_STAGES   (SYNC),
      .SETTLE_CYCLES (SETTLE),
      .STAGE_GAP     (GAP),
      .CNT_W         (8)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .hi_async_i  (hi_async_i),
      .mgmt_ena_i  (mgmt_ena_i),
      .io_ena_o    (io_ena_o),
      .la_ena_o    (la_ena_o),
      .wb_ena_o    (wb_ena_o),
      .pwr_good_o  (pwr_good_o),
      .seq_busy_o  (seq_busy_o)
`ifdef MPRJ2_SEQ_FAULT_EN
      ,
      .fault_o     (fault_o),
      .fault_cnt_o (fault_cnt_o)
`endif
   );

   // ---------------- behavioural model ----------------
   // HI is a pure delay line of SYNC samples; power is good once the delayed HI
   // has been seen high on SETTLE consecutive edges. The enables are a ladder
   // "level" (0..3) that moves one rung per GAP cycles.
   bit hist [SYNC];
   int run   = 0;
   bit m_pg  = 1'b0;
   int level = 0;
   int mode  = M_OFF;
   int tmr   = 0;
   bit m_fault = 1'b0;
   int m_fcnt  = 0;
   bit m_prev_mgmt = 1'b0;
   bit pg_pre, hs_pre;

   always @(posedge clock) begin
      pg_pre = m_pg;
      hs_pre = hist[SYNC-1];
      if (!resetn) begin
         for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
         run = 0; level = 0; mode = M_OFF; tmr = 0;
         m_fault = 1'b0; m_fcnt = 0; m_prev_mgmt = 1'b0;
      end else begin
         for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = hi_async_i;
         run = hs_pre ? run + 1 : 0;
         if ((mode == M_UP || mode == M_ON) && !pg_pre) begin
            m_fault = 1'b1;
            if (m_fcnt < 15) m_fcnt++;
         end else if (mode == M_OFF && m_prev_mgmt && !mgmt_ena_i) begin
            m_fault = 1'b0;
         end
         m_prev_mgmt = mgmt_ena_i;
         case (mode)
            M_OFF: if (pg_pre && mgmt_ena_i) begin mode = M_UP; level = 1; tmr = 0; end
            M_UP, M_ON: begin
               if (!pg_pre || !mgmt_ena_i) begin
                  mode = M_DN; level = level - 1; tmr = 0;
               end else if (mode == M_UP) begin
                  if (tmr + 1 >= GAP) begin
                     tmr = 0;
                     if (level < 3) level++; else mode = M_ON;
                  end else tmr++;
               end
            end
            default: begin
               if (!pg_pre) begin
                  mode = M_OFF; level = 0; tmr = 0;
               end else if (tmr + 1 >= GAP) begin
                  tmr = 0;
                  if (level == 0) mode = M_OFF; else level--;
               end else tmr++;
            end
         endcase
      end
      m_pg = hist[SYNC-1] && (run >= SETTLE);
   end

   function automatic bit m_io();   return level >= 1; endfunction
   function automatic bit m_la();   return level >= 2; endfunction
   function automatic bit m_wb();   return level >= 3; endfunction
   function automatic bit m_busy(); return mode == M_UP || mode == M_DN; endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, sampled away from the active edge.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("cyc_io",   int'(io_ena_o),   int'(m_io()));
         chk("cyc_la",   int'(la_ena_o),   int'(m_la()));
         chk("cyc_wb",   int'(wb_ena_o),   int'(m_wb()));
         chk("cyc_pg",   int'(pwr_good_o), int'(m_pg));
         chk("cyc_busy", int'(seq_busy_o), int'(m_busy()));
         chk("cyc_order", int'((!wb_ena_o || la_ena_o) && (!la_ena_o || io_ena_o)), 1);
`ifdef MPRJ2_SEQ_FAULT_EN
         chk("cyc_fault",    int'(fault_o),     int'(m_fault));
         chk("cyc_fault_cnt", int'(fault_cnt_o), m_fcnt);
`endif
      end
   end

   task automatic edges(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      resetn = 1'b0; hi_async_i = 1'b0; mgmt_ena_i = 1'b0;
      edges(2);
      chk_en = 1'b1;
      chk("rst_io",   int'(io_ena_o),   0);
      chk("rst_la",   int'(la_ena_o),   0);
      chk("rst_wb",   int'(wb_ena_o),   0);
      chk("rst_pg",   int'(pwr_good_o), 0);
      chk("rst_busy", int'(seq_busy_o), 0);
      resetn = 1'b1;
   endtask

   initial begin
      edges(1);
      // Power-up: pg at 18, io 19, la 23, wb 27, ON at 31.
      do_reset();
      hi_async_i = 1'b1; mgmt_ena_i = 1'b1;
      edges(17); chk("up_pg17", int'(pwr_good_o), 0); chk("model_pg17", int'(m_pg), 0);
      edges(1);  chk("up_pg18", int'(pwr_good_o), 1); chk("up_io18", int'(io_ena_o), 0);
      edges(1);  chk("up_io19", int'(io_ena_o), 1);   chk("model_io19", int'(m_io()), 1);
      edges(3);  chk("up_la22", int'(la_ena_o), 0);
      edges(1);  chk("up_la23", int'(la_ena_o), 1);   chk("model_la23", int'(m_la()), 1);
      edges(3);  chk("up_wb26", int'(wb_ena_o), 0);
      edges(1);  chk("up_wb27", int'(wb_ena_o), 1);
      edges(3);  chk("up_busy30", int'(seq_busy_o), 1);
      edges(1);  chk("up_busy31", int'(seq_busy_o), 0); chk("model_busy31", int'(m_busy()), 0);

      // Management disable in ON: wb +1, la +5, io +9, OFF +13.
      mgmt_ena_i = 1'b0;
      edges(1);  chk("dn_wb1", int'(wb_ena_o), 0); chk("dn_la1", int'(la_ena_o), 1);
      edges(3);  chk("dn_la4", int'(la_ena_o), 1);
      edges(1);  chk("dn_la5", int'(la_ena_o), 0); chk("dn_io5", int'(io_ena_o), 1);
      edges(3);  chk("dn_io8", int'(io_ena_o), 1);
      edges(1);  chk("dn_io9", int'(io_ena_o), 0); chk("dn_busy9", int'(seq_busy_o), 1);
      edges(3);  chk("dn_busy12", int'(seq_busy_o), 1);
      edges(1);  chk("dn_busy13", int'(seq_busy_o), 0); chk("model_off13", mode, M_OFF);

      // Re-enable during DN_LA: teardown finishes, then a fresh ramp.
      mgmt_ena_i = 1'b1;
      edges(14); chk("re_on", int'(wb_ena_o), 1);
      mgmt_ena_i = 1'b0;
      edges(6);  chk("re_la6", int'(la_ena_o), 0);
      mgmt_ena_i = 1'b1;
      edges(6);  chk("re_io12", int'(io_ena_o), 0); chk("re_busy12", int'(seq_busy_o), 1);
      edges(1);  chk("re_off13", int'(seq_busy_o), 0); chk("re_io13", int'(io_ena_o), 0);
      edges(1);  chk("re_io14", int'(io_ena_o), 1);
      edges(3);  chk("re_la17", int'(la_ena_o), 0);
      edges(1);  chk("re_la18", int'(la_ena_o), 1);

      // Glitch: 10 high, 1 low, then high -> pg at edge 29, not 28.
      do_reset();
      hi_async_i = 1'b1;
      edges(10); hi_async_i = 1'b0;
      edges(1);  hi_async_i = 1'b1;
      edges(17); chk("gl_pg28", int'(pwr_good_o), 0);
      edges(1);  chk("gl_pg29", int'(pwr_good_o), 1); chk("gl_io29", int'(io_ena_o), 0);

      // Power loss while in UP_LA.
      do_reset();
      hi_async_i = 1'b1; mgmt_ena_i = 1'b1;
      edges(24); hi_async_i = 1'b0;
      edges(1);  chk("pl_pg25", int'(pwr_good_o), 1);
      edges(1);  chk("pl_pg26", int'(pwr_good_o), 0); chk("pl_la26", int'(la_ena_o), 1);
      edges(1);  chk("pl_la27", int'(la_ena_o), 0);   chk("pl_io27", int'(io_ena_o), 1);
                 chk("pl_busy27", int'(seq_busy_o), 1);
`ifdef MPRJ2_SEQ_FAULT_EN
                 chk("pl_fault27", int'(fault_o), 1); chk("pl_fcnt27", int'(fault_cnt_o), 1);
`endif
      edges(1);  chk("pl_io28", int'(io_ena_o), 0);   chk("pl_busy28", int'(seq_busy_o), 0);

      // Reset during UP_WB, then a full restart from the synchronizer.
      do_reset();
      hi_async_i = 1'b1; mgmt_ena_i = 1'b1;
      edges(28); chk("rw_wb28", int'(wb_ena_o), 1);
      resetn = 1'b0;
      edges(1);  chk("rw_io", int'(io_ena_o), 0); chk("rw_wb", int'(wb_ena_o), 0);
                 chk("rw_pg", int'(pwr_good_o), 0); chk("rw_busy", int'(seq_busy_o), 0);
      resetn = 1'b1;
      edges(18); chk("rw_io18", int'(io_ena_o), 0);
      edges(1);  chk("rw_io19", int'(io_ena_o), 1);

      // Random traffic; the per-cycle compare carries the checking.
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(0, 69) == 0) hi_async_i = ~hi_async_i;
         if ($urandom_range(0, 49) == 0) mgmt_ena_i = ~mgmt_ena_i;
         resetn = ($urandom_range(0, 799) != 0);
         edges(1);
      end
      resetn = 1'b1;
      edges(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mprj2_enable_sequencer.md
Name: mprj2_enable_sequencer

Overview:
- Consumes the user-area power domain 2 tie-high "power present" signal (vccd2-domain HI) at the management side; crosses it into the management clock domain.
- Debounces it and sequences staged enables to the domain-2 user project: I/O gating first, then logic-analyzer (LA) gating, then Wishbone gating.
- Tears the enables down in reverse order on loss of HI or on a management disable.
- Sits in mgmt_protect, between the domain-2 tie cell and the domain-2 gating buffers.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the HI synchronizer (minimum 2).
- SETTLE_CYCLES, 16, consecutive cycles the synchronized HI must stay 1 before sequencing starts (minimum 1).
- STAGE_GAP, 4, cycles between successive enable assertions and deassertions (minimum 1).
- CNT_W, 8, counter width; must satisfy 2^CNT_W > max(SETTLE_CYCLES, STAGE_GAP).

Ports:
- clock  in  1  management clock.
- resetn  in  1  synchronous reset, active-low.
- hi_async_i  in  1  domain-2 tie-high, asynchronous to clock; 0 while vccd2 is down.
- mgmt_ena_i  in  1  management request to enable domain 2 (level).
- io_ena_o  out  1  domain-2 I/O gating enable.
- la_ena_o  out  1  domain-2 LA gating enable.
- wb_ena_o  out  1  domain-2 Wishbone gating enable.
- pwr_good_o  out  1  debounced, synchronized HI.
- seq_busy_o  out  1  sequencer is in a transitional state.

Behaviour:
- Reset (resetn=0 at a clock edge): all synchronizer flops 0, counter 0, state OFF, every output 0. Reset has priority over every other event, including a reset asserted mid-sequence.
- Synchronizer: hi_async_i passes through a SYNC_STAGES flop chain; the result is hi_s.
- Debounce:
  - hi_s=0 clears the settle counter and drops pwr_good_o on the same cycle hi_s is seen.
  - pwr_good_o rises on the clock edge after hi_s has been 1 for SETTLE_CYCLES consecutive cycles.
  - The counter saturates; it does not wrap.
- FSM states: OFF, UP_IO, UP_LA, UP_WB, ON, DN_WB, DN_LA, DN_IO.
- Transitions:
  - OFF -> UP_IO when pwr_good_o & mgmt_ena_i. Entering UP_IO asserts io_ena_o.
  - UP_IO, after STAGE_GAP cycles -> UP_LA (asserts la_ena_o).
  - UP_LA, after STAGE_GAP cycles -> UP_WB (asserts wb_ena_o).
  - UP_WB, after STAGE_GAP cycles -> ON.
  - Any UP_* or ON, when !pwr_good_o or !mgmt_ena_i, -> DN entry at the matching level:
    - wb_ena_o set -> DN_WB, which drops wb_ena_o immediately.
    - else la_ena_o set -> DN_LA.
    - else -> DN_IO.
  - DN_WB, after STAGE_GAP cycles -> DN_LA (drops la_ena_o).
  - DN_LA, after STAGE_GAP cycles -> DN_IO (drops io_ena_o).
  - DN_IO, after STAGE_GAP cycles -> OFF.
- Loss of power (pwr_good_o=0) during any DN_* state: all enables drop on the next edge and the FSM goes directly to OFF.
- Teardown is not interruptible: mgmt_ena_i re-asserting during DN_* has no effect until OFF is reached; re-enable then starts a full up-sequence.
- Enable ordering invariants:
  - wb_ena_o implies la_ena_o.
  - la_ena_o implies io_ena_o.
- seq_busy_o = 1 in every UP_* and DN_* state; 0 in OFF and ON.
- Latency: from hi_async_i rising with mgmt_ena_i=1 to io_ena_o = SYNC_STAGES + SETTLE_CYCLES + 1 cycles.
- The stage-gap counter reloads to 0 on every state change.

Optional Feature:
- Macro: MPRJ2_SEQ_FAULT_EN.
- When defined, adds:
  - Output fault_o (1 bit), sticky. Set when pwr_good_o falls while the state is ON or any UP_* state. Cleared only by reset, or by a mgmt_ena_i 1->0 edge while in OFF.
  - Output fault_cnt_o (4 bits), saturating at 15, counting such events.
- When undefined: neither port exists and no fault logic is generated.

Decomposition:
- Package mprj2_seq_pkg holds:
  - the state enum (3-bit encoding, OFF=0);
  - the default constants for SYNC_STAGES, SETTLE_CYCLES and STAGE_GAP.
- Sub-module mprj2_hi_debounce: synchronizer chain plus settle counter; produces pwr_good_o. The top-level block instantiates it once.

Test Plan:
- Reset then power-up: hi_async_i=1, mgmt_ena_i=1, defaults -> io_ena_o rises at cycle 19; la_ena_o at 23; wb_ena_o at 27; seq_busy_o low from 31.
- Glitch: hi_async_i high for 10 cycles, low for 1, then high -> pwr_good_o stays 0 until 16 consecutive synchronized-high cycles after the glitch.
- Management disable in ON: mgmt_ena_i 1->0 -> wb_ena_o drops at +1, la_ena_o at +5, io_ena_o at +9; OFF reached at +13.
- Power loss mid-UP_LA: hi_async_i->0 -> after 2-cycle sync, pwr_good_o=0 and teardown enters DN_LA; with the macro, fault_o=1 and fault_cnt_o=1.
- Reset asserted during UP_WB: resetn=0 for 1 cycle -> all outputs 0 on that edge; state OFF.
- Re-enable during DN_LA: mgmt_ena_i pulses back to 1 -> teardown completes to OFF, then a fresh UP_IO follows with the same stage timing.
